// File: rtl/pkwars_pkg.sv
// pkwars_pkg: shared ROM-map constants and ROM loader state type
package pkwars_pkg;
    localparam logic [16:0] IMG_BYTES = 17'h1A020;
    localparam logic [16:0] PRG0_BASE = 17'h10000;
    localparam logic [16:0] PRG1_BASE = 17'h18000;
    localparam logic [16:0] PAL_BASE  = 17'h1A000;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} ld_state_e;
endpackage

// File: rtl/pkwars_word_fifo.sv
// pkwars_word_fifo: synchronous word buffer ({addr,data} entries) with full/empty flags
module pkwars_word_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    assign rdata_o = mem_q[rp_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wp_q] <= wdata_i;
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + 1'b1;
            if (pop_i) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end
endmodule

// File: rtl/pkwars_rom_loader.sv
// pkwars_rom_loader: HPS 16-bit download stream -> byte-wide ROM bank write strobes.
// Optional PKWARS_LOADER_CHKSUM_EN adds an additive checksum gating LOADED.
module pkwars_rom_loader #(
    parameter logic [16:0] IMG_BYTES  = pkwars_pkg::IMG_BYTES,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [7:0]  DL_IDX     = 8'h00,
    parameter logic [7:0]  CHK_EXPECT = 8'h00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dl_act_i,
    input  logic [7:0]  dl_index_i,
    input  logic        dl_wr_i,
    input  logic [24:0] dl_addr_i,
    input  logic [15:0] dl_data_i,
    output logic        dl_wait_o,
    output logic [16:0] romad_o,
    output logic [7:0]  romdt_o,
    output logic        romen_o,
    output logic        loaded_o,
    output logic        dl_err_o
`ifdef PKWARS_LOADER_CHKSUM_EN
    ,
    output logic [7:0]  chksum_o,
    output logic        chk_ok_o
`endif
);
    import pkwars_pkg::*;
    ld_state_e   state_q;
    logic        act_q, phase_q, romen_q, loaded_q, err_q;
    logic [16:0] cnt_q, romad_q;
    logic [7:0]  romdt_q, emit_byte;
    logic [31:0] head, in_word, src;
    logic        full, empty, wr_ok, src_valid, src_bad, emit, pop, push, chk_match;
    logic        unused_ok;
    // High address bits are folded into an all-ones word address so the range check still rejects them.
    assign in_word   = {(|dl_addr_i[24:17]) ? 16'hFFFF : dl_addr_i[16:1], dl_data_i};
    assign wr_ok     = dl_wr_i && state_q == LOAD;
    assign src       = empty ? in_word : head;
    assign src_valid = !empty || wr_ok;
    assign src_bad   = {src[31:16], 1'b0} >= IMG_BYTES;
    assign emit      = src_valid && !src_bad;
    assign emit_byte = phase_q ? src[15:8] : src[7:0];
    assign pop       = !empty && (phase_q || src_bad);
    assign push      = wr_ok && (!full || pop) && !(empty && src_bad);
    assign unused_ok = ^{dl_addr_i[0], CHK_EXPECT, PRG0_BASE, PRG1_BASE, PAL_BASE};
    pkwars_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_word),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );
`ifdef PKWARS_LOADER_CHKSUM_EN
    logic [7:0] sum_q;
    assign chk_match = sum_q == CHK_EXPECT;
    assign chksum_o  = sum_q;
    assign chk_ok_o  = state_q == DONE && chk_match;
    always_ff @(posedge clk_i) begin
        if (reset_i || (state_q != LOAD && state_q != DRAIN && dl_act_i && !act_q && dl_index_i == DL_IDX))
            sum_q <= '0;
        else if (emit)
            sum_q <= sum_q + emit_byte;
    end
`else
    assign chk_match = 1'b1;
`endif
    assign dl_wait_o = full;
    assign romad_o   = romad_q;
    assign romdt_o   = romdt_q;
    assign romen_o   = romen_q;
    assign loaded_o  = loaded_q;
    assign dl_err_o  = err_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            act_q    <= 1'b0;
            phase_q  <= 1'b0;
            romen_q  <= 1'b0;
            romad_q  <= '0;
            romdt_q  <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            act_q   <= dl_act_i;
            romen_q <= emit;
            if (emit) begin
                romad_q <= {src[31:16], phase_q};
                romdt_q <= emit_byte;
                phase_q <= ~phase_q;
                if (cnt_q != IMG_BYTES) cnt_q <= cnt_q + 17'd1;
            end
            if (wr_ok && full && !pop) err_q <= 1'b1;
            case (state_q)
                IDLE, DONE: if (dl_act_i && !act_q && dl_index_i == DL_IDX) begin
                    state_q  <= LOAD;
                    cnt_q    <= '0;
                    loaded_q <= 1'b0;
                    err_q    <= 1'b0;
                end
                LOAD: if (!dl_act_i) state_q <= DRAIN;
                DRAIN: if (empty && !phase_q) begin
                    state_q  <= DONE;
                    loaded_q <= cnt_q == IMG_BYTES && !err_q && chk_match;
                    if (cnt_q != IMG_BYTES) err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkwars_rom_loader.sv
// tb_pkwars_rom_loader: directed vector table plus hand sequences for the ROM download writer
module tb_pkwars_rom_loader;
    localparam logic [16:0] IMG = 17'h0040;
    logic        clk_i = 0, reset_i = 1, dl_act_i = 0, dl_wr_i = 0;
    logic [7:0]  dl_index_i = 0;
    logic [24:0] dl_addr_i = 0;
    logic [15:0] dl_data_i = 0;
    logic        dl_wait_o, romen_o, loaded_o, dl_err_o;
    logic [16:0] romad_o;
    logic [7:0]  romdt_o;
`ifdef PKWARS_LOADER_CHKSUM_EN
    logic [7:0]  chksum_o;
    logic        chk_ok_o;
`endif
    int ncmp = 0, nbad = 0, pulses = 0, p0;
    logic        mon_chk = 0;
    logic [16:0] exp_ad = 0;

    pkwars_rom_loader #(.IMG_BYTES(IMG), .FIFO_DEPTH(2), .DL_IDX(8'h00), .CHK_EXPECT(8'hE0)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .dl_act_i(dl_act_i), .dl_index_i(dl_index_i),
        .dl_wr_i(dl_wr_i), .dl_addr_i(dl_addr_i), .dl_data_i(dl_data_i), .dl_wait_o(dl_wait_o),
        .romad_o(romad_o), .romdt_o(romdt_o), .romen_o(romen_o), .loaded_o(loaded_o),
        .dl_err_o(dl_err_o)
`ifdef PKWARS_LOADER_CHKSUM_EN
        , .chksum_o(chksum_o), .chk_ok_o(chk_ok_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        dl_act_i = 0;
        step();
        dl_index_i = idx;
        dl_act_i = 1;
        step();
    endtask

    task automatic wr_word(input logic [24:0] a, input logic [15:0] d);
        dl_wr_i = 1;
        dl_addr_i = a;
        dl_data_i = d;
        step();
        dl_wr_i = 0;
        step();
    endtask

    // Images use data == byte address, so each byte is predictable from its position.
    always @(negedge clk_i) begin
        if (romen_o) begin
            pulses++;
            if (mon_chk) begin
                chk("romad_seq", 64'(romad_o), 64'(exp_ad));
                chk("romdt_seq", 64'(romdt_o), 64'(exp_ad[0] ? 8'h00 : {exp_ad[7:1], 1'b0}));
                exp_ad++;
            end
        end
    end

    typedef struct {
        logic act; logic wr; logic [24:0] addr; logic [15:0] data;
        logic en; logic [16:0] ad; logic [7:0] dt; logic wt; logic er; logic ld;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 0, 25'h0, 16'h0000, 0, 17'h0, 8'h00, 0, 0, 0};
        tbl[1]  = '{1, 1, 25'h0, 16'hA1B2, 1, 17'h0, 8'hB2, 0, 0, 0};
        tbl[2]  = '{1, 1, 25'h2, 16'hC3D4, 1, 17'h1, 8'hA1, 0, 0, 0};
        tbl[3]  = '{1, 1, 25'h4, 16'hE5F6, 1, 17'h2, 8'hD4, 1, 0, 0};
        tbl[4]  = '{1, 1, 25'h6, 16'h0718, 1, 17'h3, 8'hC3, 1, 0, 0};
        tbl[5]  = '{1, 1, 25'h8, 16'h292A, 1, 17'h4, 8'hF6, 1, 1, 0};
        tbl[6]  = '{1, 0, 25'h0, 16'h0000, 1, 17'h5, 8'hE5, 0, 1, 0};
        tbl[7]  = '{1, 0, 25'h0, 16'h0000, 1, 17'h6, 8'h18, 0, 1, 0};
        tbl[8]  = '{1, 0, 25'h0, 16'h0000, 1, 17'h7, 8'h07, 0, 1, 0};
        tbl[9]  = '{1, 0, 25'h0, 16'h0000, 0, 17'h7, 8'h07, 0, 1, 0};
        tbl[10] = '{0, 0, 25'h0, 16'h0000, 0, 17'h7, 8'h07, 0, 1, 0};
        tbl[11] = '{0, 0, 25'h0, 16'h0000, 0, 17'h7, 8'h07, 0, 1, 0};

        step();
        step();
        chk("reset_state", 64'({romen_o, romad_o, romdt_o, dl_wait_o, dl_err_o, loaded_o}), 64'h0);
        reset_i = 0;
        step();

        // Back-pressure with DL_WAIT ignored: the fifth word lands on a full, non-popping FIFO.
        for (int i = 0; i < 12; i++) begin
            dl_act_i = tbl[i].act;
            dl_wr_i = tbl[i].wr;
            dl_addr_i = tbl[i].addr;
            dl_data_i = tbl[i].data;
            step();
            chk($sformatf("vec%0d", i),
                64'({romen_o, romad_o, romdt_o, dl_wait_o, dl_err_o, loaded_o}),
                64'({tbl[i].en, tbl[i].ad, tbl[i].dt, tbl[i].wt, tbl[i].er, tbl[i].ld}));
        end
        dl_wr_i = 0;

        // Full image, writer honours DL_WAIT.
        start_dl(8'h00);
        chk("load_clears_err", 64'({dl_err_o, loaded_o}), 64'h0);
        mon_chk = 1;
        exp_ad = 0;
        p0 = pulses;
        begin
            int w = 0;
            for (int g = 0; g < 400 && w < 32; g++) begin
                if (!dl_wait_o) begin
                    dl_wr_i = 1;
                    dl_addr_i = 25'(w * 2);
                    dl_data_i = 16'(w * 2);
                    w++;
                end else dl_wr_i = 0;
                step();
            end
            chk("full_words_sent", 64'(w), 64'd32);
        end
        dl_wr_i = 0;
        dl_act_i = 0;
        for (int i = 0; i < 40 && !loaded_o; i++) step();
        chk("full_loaded", 64'(loaded_o), 64'd1);
        chk("full_err", 64'(dl_err_o), 64'd0);
        chk("full_pulses", 64'(pulses - p0), 64'd64);
        chk("full_last_ad", 64'(romad_o), 64'h3F);
`ifdef PKWARS_LOADER_CHKSUM_EN
        chk("full_chksum", 64'(chksum_o), 64'hE0);
        chk("full_chk_ok", 64'(chk_ok_o), 64'd1);
`endif

        // Non-matching index: nothing accepted, LOADED retained.
        p0 = pulses;
        start_dl(8'h01);
        wr_word(25'h0, 16'h0000);
        wr_word(25'h2, 16'h0002);
        dl_act_i = 0;
        for (int i = 0; i < 5; i++) step();
        chk("badidx_pulses", 64'(pulses - p0), 64'd0);
        chk("badidx_loaded", 64'({loaded_o, dl_err_o}), 64'b10);

        // Out-of-range words are consumed silently and do not count toward the image.
        start_dl(8'h00);
        exp_ad = 0;
        p0 = pulses;
        wr_word(25'h1A020, 16'h5A5A);
        wr_word(25'h20000, 16'h6B6B);
        wr_word(25'h40, 16'h7C7C);
        chk("oob_no_romen", 64'(pulses - p0), 64'd0);
        chk("oob_no_wait", 64'(dl_wait_o), 64'd0);
        for (int w = 0; w < 30; w++) wr_word(25'(w * 2), 16'(w * 2));
        dl_act_i = 0;
        for (int i = 0; i < 40 && !dl_err_o; i++) step();
        chk("oob_short_err", 64'(dl_err_o), 64'd1);
        chk("oob_short_loaded", 64'(loaded_o), 64'd0);
        chk("oob_pulses", 64'(pulses - p0), 64'd60);

        // Reset right after the even byte: odd byte never appears.
        start_dl(8'h00);
        exp_ad = 0;
        p0 = pulses;
        dl_wr_i = 1;
        dl_addr_i = 25'h0;
        dl_data_i = 16'h0000;
        step();
        chk("rst_even_byte", 64'({romen_o, romad_o}), 64'({1'b1, 17'h0}));
        dl_wr_i = 0;
        reset_i = 1;
        step();
        chk("rst_romen_low", 64'({romen_o, dl_wait_o, dl_err_o, loaded_o}), 64'h0);
        reset_i = 0;
        for (int i = 0; i < 4; i++) step();
        chk("rst_no_odd_byte", 64'(pulses - p0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
